// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
//   dmem_state_t : responder FSM state encoding
//   WORD_BYTES   : bytes per storage word
//   idx_width()  : word-index width for a given storage depth
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    localparam int unsigned WORD_BYTES = 4;

    // Never return 0 so the index bus always has at least one bit.
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? int'($clog2(depth)) : 1;
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port word storage with per-byte write enables.
//   clk_i   : clock
//   en_i    : access enable (one access per enabled edge)
//   we_i    : 1 = write enabled bytes, 0 = read
//   addr_i  : word index
//   wdata_i : write data
//   wstrb_i : byte enables, bit i covers wdata_i[8i+7:8i]
//   rdata_o : read data, registered on the enabled read edge and held
// The array has no reset; contents survive a controller reset.
module dmem_sram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned IDX_W = 10
) (
    input  logic             clk_i,
    input  logic             en_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] addr_i,
    input  logic [31:0]      wdata_i,
    input  logic [3:0]       wstrb_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (wstrb_i[b]) begin
                        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core load/store port.
//   clk, reset            : clock, synchronous active-high reset
//   req_valid / req_ready : request handshake
//   req_we, req_addr      : store flag, byte address
//   req_wdata, req_wstrb  : store data and byte enables
//   rsp_valid / rsp_ready : response handshake
//   rsp_rdata             : load data (0 for stores and errors)
//   rsp_err               : misaligned or out-of-range access
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | ready for a request; request fields latched on acceptance
// WAIT  | wait states; lasts WAIT_STATES+1 cycles, the access is performed
//       | on the edge leaving this state
// RESP  | response presented and held until rsp_ready
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W = idx_width(DEPTH_WORDS);
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) * 33'(WORD_BYTES);

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        accept;

    logic [31:0] offset;
    logic        acc_err;
    logic        commit;
    logic        sram_en;
    logic [31:0] sram_rdata;

    // Addresses below BASE_ADDR wrap to large offsets and fail the range check.
    assign offset  = addr_q - BASE_ADDR;
    assign acc_err = (offset[1:0] != 2'b00) || ({1'b0, offset} >= SPAN);

    // A reset on the commit edge drops the pending store.
    assign commit  = (state_q == WAIT) && (cnt_q == 4'd0);
    assign sram_en = commit && !acc_err && !reset;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        req_ready   = 1'b0;
        accept      = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = WAIT;
                    cnt_d   = 4'(WAIT_STATES);
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = acc_err;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
            end
        end
    end

    dmem_sram #(
        .DEPTH (DEPTH_WORDS),
        .IDX_W (IDX_W)
    ) u_sram (
        .clk_i   (clk),
        .en_i    (sram_en),
        .we_i    (we_q),
        .addr_i  (offset[IDX_W+1:2]),
        .wdata_i (wdata_q),
        .wstrb_i (wstrb_q),
        .rdata_o (sram_rdata)
    );

    // The SRAM read register holds its value through RESP; gate it so stores,
    // errors and the idle state all present zero.
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = (rsp_valid_q && !rsp_err_q && !we_q) ? sram_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int unsigned D0 = 1024;
    localparam int unsigned W0 = 2;
    localparam logic [31:0] B0 = 32'h0000_0000;
    localparam int unsigned D1 = 16;
    localparam int unsigned W1 = 0;
    localparam logic [31:0] B1 = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        req_valid, req_we, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rq0, rq1, rv0, rv1, er0, er1;
    logic [31:0] rd0, rd1;
    logic        rq, rv, er;
    logic [31:0] rd;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          acc_cyc;
    byte         mem_model [longint];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH_WORDS(D0), .WAIT_STATES(W0), .BASE_ADDR(B0)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid & ~sel), .req_ready(rq0),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_rdata(rd0), .rsp_err(er0));

    dmem_responder #(.DEPTH_WORDS(D1), .WAIT_STATES(W1), .BASE_ADDR(B1)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid & sel), .req_ready(rq1),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_rdata(rd1), .rsp_err(er1));

    assign rq = sel ? rq1 : rq0;
    assign rv = sel ? rv1 : rv0;
    assign er = sel ? er1 : er0;
    assign rd = sel ? rd1 : rd0;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: byte-addressed sparse memory per instance; error rule from
    // the address window with signed arithmetic.
    function automatic void model(input bit s, input bit we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] wstrb,
                                  output logic [31:0] r, output bit err, output bit known);
        longint base  = s ? longint'(B1) : longint'(B0);
        longint depth = s ? longint'(D1) : longint'(D0);
        longint off   = longint'(addr) - base;
        longint key   = (s ? 64'h1_0000_0000 : 64'h0) + longint'(addr);
        err   = (addr[1:0] != 2'b00) || (off < 0) || (off >= depth * 4);
        r     = 32'h0;
        known = 1'b1;
        if (!err) begin
            for (int b = 0; b < 4; b++) begin
                if (we) begin
                    if (wstrb[b]) mem_model[key + b] = byte'(wdata >> (8 * b));
                end else if (mem_model.exists(key + b)) begin
                    r[8*b +: 8] = mem_model[key + b];
                end else begin
                    known = 1'b0;
                end
            end
        end
    endfunction

    task automatic send_req(input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr;
        req_wdata = wdata; req_wstrb = wstrb;
        chk("req_ready_idle", rq, 1'b1);
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        forever begin
            @(posedge clk);
            #1;
            lat++;
            if (rv) break;
            if (lat > 40) begin
                chk("rsp_timeout", 32'(lat), 32'd0);
                break;
            end
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rsp_valid_cleared", rv, 1'b0);
        chk("rsp_rdata_cleared", rd, 32'h0);
        chk("rsp_err_cleared", er, 1'b0);
        chk("req_ready_after_hs", rq, 1'b1);
    endtask

    task automatic do_txn(input string nm, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb, input int hold,
                          output logic [31:0] r, output bit e);
        int lat;
        rsp_ready = (hold == 0);
        send_req(we, addr, wdata, wstrb);
        wait_rsp(lat);
        chk({nm, "_latency"}, 32'(lat), 32'((sel ? W1 : W0) + 1));
        r = rd;
        e = er;
        for (int i = 0; i < hold; i++) begin
            if (i == 2) begin
                req_valid = 1'b1; req_we = 1'b1; req_addr = addr;
                req_wdata = ~wdata; req_wstrb = 4'hF;
            end
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            chk({nm, "_hold_valid"}, rv, 1'b1);
            chk({nm, "_hold_rdata"}, rd, r);
            chk({nm, "_hold_err"}, er, e);
            chk({nm, "_hold_req_ready"}, rq, 1'b0);
        end
        finish_rsp();
    endtask

    task automatic model_txn(input string nm, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] wstrb, input int hold);
        logic [31:0] r, er_unused, mr;
        bit e, me, known;
        er_unused = 32'h0;
        model(sel, we, addr, wdata, wstrb, mr, me, known);
        do_txn(nm, we, addr, wdata, wstrb, hold, r, e);
        chk({nm, "_err"}, e, me);
        if (known) chk({nm, "_rdata"}, r, mr);
        else if (me) chk({nm, "_rdata"}, r, er_unused);
    endtask

    function automatic logic [31:0] rand_addr(input bit s);
        logic [31:0] base  = s ? B1 : B0;
        logic [31:0] span  = s ? 32'(D1 * 4) : 32'(D0 * 4);
        int unsigned k = $urandom_range(0, 9);
        case (k)
            0: rand_addr = (base != 0) ? base - 32'd4 : base + span + 32'd4;
            1: rand_addr = base + span;
            2: rand_addr = base + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(1, 3));
            3: rand_addr = base + span - 32'd4;
            default: rand_addr = base + 32'(4 * $urandom_range(0, 7));
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        logic [31:0] r, mr;
        bit e, me, known;
        int a0, lat;

        reset = 1'b1; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", rq0, 1'b1);
        chk("rst_rsp_valid", rv0, 1'b0);
        chk("rst_rsp_rdata", rd0, 32'h0);
        chk("rst_rsp_err", er0, 1'b0);
        chk("rst_req_ready_z", rq1, 1'b1);
        chk("rst_rsp_valid_z", rv1, 1'b0);
        reset = 1'b0;

        vecs.push_back('{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h20,  32'h11223344, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 32'h20,  32'hAABBCCDD, 4'h5, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h20,  32'h0,        4'h0, 32'h11BB33DD, 1'b0});
        vecs.push_back('{1'b0, 32'h22,  32'h0,        4'h0, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'hFFC, 32'h12345678, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 32'h1000,32'hFFFFFFFF, 4'hF, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'hFFC, 32'h0,        4'h0, 32'h12345678, 1'b0});
        vecs.push_back('{1'b1, 32'h20,  32'hFFFFFFFF, 4'h0, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h20,  32'h0,        4'h0, 32'h11BB33DD, 1'b0});
        foreach (vecs[i]) begin
            model(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, mr, me, known);
            do_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   vecs[i].wstrb, 0, r, e);
            chk($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
        end

        // Backpressure with an ignored request pulse in the RESP window.
        model_txn("bp_load", 1'b0, 32'h10, 32'h0, 4'h0, 5);
        model_txn("bp_after", 1'b0, 32'h10, 32'h0, 4'h0, 0);

        // Back-to-back spacing, WAIT_STATES=2.
        model_txn("b2b_a", 1'b0, 32'h20, 32'h0, 4'h0, 0);
        a0 = acc_cyc;
        model_txn("b2b_b", 1'b0, 32'h20, 32'h0, 4'h0, 0);
        chk("b2b_period_w2", 32'(acc_cyc - a0), 32'(W0 + 3));

        // Reset during WAIT drops the store.
        model_txn("rw_pre", 1'b1, 32'h40, 32'h5, 4'hF, 0);
        send_req(1'b1, 32'h40, 32'h99, 4'hF);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rw_rsp_valid", rv0, 1'b0);
        chk("rw_req_ready", rq0, 1'b1);
        reset = 1'b0;
        model_txn("rw_load", 1'b0, 32'h40, 32'h0, 4'h0, 0);

        // Reset during RESP keeps the committed store.
        rsp_ready = 1'b0;
        send_req(1'b1, 32'h44, 32'h77, 4'hF);
        model(1'b0, 1'b1, 32'h44, 32'h77, 4'hF, mr, me, known);
        wait_rsp(lat);
        chk("rr_latency", 32'(lat), 32'(W0 + 1));
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rr_rsp_valid", rv0, 1'b0);
        chk("rr_rsp_rdata", rd0, 32'h0);
        reset = 1'b0;
        model_txn("rr_load", 1'b0, 32'h44, 32'h0, 4'h0, 0);

        // Zero-wait instance.
        sel = 1'b1;
        model_txn("z_store", 1'b1, 32'h1004, 32'hCAFEF00D, 4'hF, 0);
        a0 = acc_cyc;
        model_txn("z_load", 1'b0, 32'h1004, 32'h0, 4'h0, 0);
        chk("b2b_period_w0", 32'(acc_cyc - a0), 32'(W1 + 3));
        model_txn("z_last", 1'b0, 32'h103C, 32'h0, 4'h0, 0);
        model_txn("z_below", 1'b0, 32'h0FFC, 32'h0, 4'h0, 0);
        model_txn("z_end", 1'b1, 32'h1040, 32'h1, 4'hF, 0);

        // Randomized traffic on both instances.
        for (int n = 0; n < 120; n++) begin
            sel = (n >= 70);
            model_txn($sformatf("rnd%0d", n), 1'($urandom), rand_addr(sel), $urandom,
                      4'($urandom), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the RISC-V core's load/store port. It accepts one word-granular read or write request at a time over a valid/ready handshake and inserts a configurable number of wait states. It returns the read data, or a write acknowledge, over a second valid/ready handshake. It sits between the core's memory interface (address, write data, read data) and on-chip word storage. It also flags misaligned and out-of-range accesses.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words of storage (power of two, >= 2)
WAIT_STATES, 2, extra cycles between request acceptance and response (0..15)
BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*4

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data
req_wstrb  input  4  byte enables for store; bit i enables wdata[8i+7:8i]
rsp_valid  output  1  response present
rsp_ready  input  1  requester accepts response
rsp_rdata  output  32  load data; 0 for stores and for errors
rsp_err  output  1  access misaligned (addr[1:0]!=0) or outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4)

Behaviour:
- Reset:
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - Storage contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch we, addr, wdata, wstrb.
  - If WAIT_STATES==0, go to RESP; otherwise go to WAIT with counter=WAIT_STATES-1.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle; at counter==0, go to RESP.
- Entry into RESP (single edge), with the access performed on that edge:
  - Load: rsp_rdata = mem[word index].
  - Store: each byte with wstrb=1 is written; rsp_rdata=0.
  - Error: no storage write, rsp_rdata=0, rsp_err=1.
  - rsp_valid=1.
- Latency: rsp_valid rises exactly WAIT_STATES+1 cycles after the accepting edge.
- RESP:
  - req_ready=0.
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE and clear rsp_valid, rsp_rdata and rsp_err on the same edge.
- Throughput: at most one outstanding request. A new request is accepted no earlier than the cycle after the response handshake.
- Word index = (req_addr - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits after the range check.
- Store with wstrb=4'b0000: no bytes written, response still returned with rsp_err=0.
- Last word (BASE_ADDR+DEPTH_WORDS*4-4): valid access. The first byte past the end is an error; there is no wrap-around.
- rsp_ready held high permanently: the response is consumed in the first RESP cycle, giving WAIT_STATES+3 cycles per transaction.
- req_valid is ignored outside IDLE. Request inputs need not be stable after acceptance.
- Reset asserted mid-transaction (WAIT or RESP) aborts it:
  - A store not yet committed is dropped.
  - A store already committed at RESP entry remains in storage.
  - Outputs return to reset values on the next edge.
- A read returns data from the storage state before the same-edge store commit; only one access occurs per transaction, so there is no read/write conflict.

Decomposition:
- Package dmem_pkg:
  - typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t
  - localparam WORD_BYTES=4
  - localparam function for index width (clog2 of DEPTH_WORDS)
- Sub-module dmem_sram holds the storage:
  - Single-port, 32-bit, byte-enable write, synchronous read.
  - Read data registered on the enable edge.
  - No reset on the array.

Test Plan:
- Store/load round trip, WAIT_STATES=2, rsp_ready=1: store 0xDEADBEEF to 0x10 with wstrb=4'hF. rsp_valid rises 3 cycles after the accept edge with rsp_rdata=0, rsp_err=0. A load from 0x10 then returns 0xDEADBEEF.
- Byte strobes: store 0x11223344 to 0x20 with wstrb=4'hF, then store 0xAABBCCDD to 0x20 with wstrb=4'b0101. A load from 0x20 returns 0x11BB33DD.
- Errors: load from 0x22 (misaligned) returns rsp_err=1, rsp_rdata=0. A store to BASE_ADDR+DEPTH_WORDS*4 returns rsp_err=1, and a load from the last word afterwards is unchanged. A load from BASE_ADDR+4*DEPTH_WORDS-4 returns rsp_err=0.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP. rsp_valid, rsp_rdata and rsp_err stay stable, req_ready=0, and a req_valid pulse in that window is not accepted. After the handshake, req_ready=1 on the next cycle.
- Zero-wait configuration (WAIT_STATES=0): rsp_valid rises 1 cycle after acceptance. Back-to-back requests with rsp_ready=1 complete one every 3 cycles.
- Reset mid-operation: assert reset in WAIT during a store to 0x40 holding 0x5. The next cycle has rsp_valid=0, req_ready=1, and a load from 0x40 still returns 0x5.
